// File: rtl/airlock_pkg.sv
// airlock_pkg: shared FSM state, session side and default tick constants for the airlock scheduler
package airlock_pkg;
  typedef enum logic [2:0] {IDLE, DOOR_IN, DOOR_OUT, WAIT_EVAC, EVAC, WAIT_PRESS, PRESS, HOLD} state_t;
  typedef enum logic {ARRIVE, DEPART} side_t;
  localparam int DEF_EVAC_TICKS = 5;
  localparam int DEF_PRESS_TICKS = 7;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/airlock_pump_timer.sv
// airlock_pump_timer: saturating tick counter with clear, run/freeze gating and terminal-count done
module airlock_pump_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);
  assign done = run && tick && ({1'b0, count} + (CNT_W+1)'(1) == {1'b0, limit});
  // count ticks while running; the tick reaching the limit wraps the count back to zero
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clear || done) count <= '0;
    else if (run && tick && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/airlock_scheduler.sv
// airlock_scheduler: one-chamber session arbiter, door/pump sequencer and permit generator; define AIRLOCK_AUTO_PUMP_EN to start pump phases on tick instead of operator pulses
module airlock_scheduler
  import airlock_pkg::*;
#(
  parameter int EVAC_TICKS = DEF_EVAC_TICKS,
  parameter int PRESS_TICKS = DEF_PRESS_TICKS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             arrive_req,
  input  logic             depart_req,
  input  logic             outer_open,
  input  logic             inner_open,
  input  logic             evacuate,
  input  logic             pressurize,
  output logic             grant_arrive,
  output logic             grant_depart,
  output logic             outer_ok,
  output logic             inner_ok,
  output logic             pumping,
  output logic             pressurized,
  output logic             fault,
  output logic [CNT_W-1:0] seconds
);
  state_t state, nextState;
  side_t side, nextSide, lastServed, nextLast;
  logic leg, nextLeg, doorSeen, nextSeen, anyOpened, nextOpened, nextPress, faultNext;
  logic timerClear, timerRun, timerDone, doorsClosed, pumpGo, reqHeld, mineOpen, otherOpen;
  logic [CNT_W-1:0] limit;
  assign doorsClosed = !outer_open && !inner_open;
  assign timerRun = (state == EVAC || state == PRESS) && doorsClosed;
  assign limit = pressurized ? CNT_W'(EVAC_TICKS) : CNT_W'(PRESS_TICKS);
  assign reqHeld = side == ARRIVE ? arrive_req : depart_req;
  assign mineOpen = state == DOOR_OUT ? outer_open : inner_open;
  assign otherOpen = state == DOOR_OUT ? inner_open : outer_open;
`ifdef AIRLOCK_AUTO_PUMP_EN
  assign pumpGo = tick;
`else
  assign pumpGo = state == WAIT_EVAC ? evacuate && !pressurize : pressurize && !evacuate;
`endif
  airlock_pump_timer #(.CNT_W(CNT_W)) timer (
    .clock(clock),
    .reset(reset),
    .tick(tick),
    .run(timerRun),
    .clear(timerClear),
    .limit(limit),
    .count(seconds),
    .done(timerDone)
  );
  // session sequencing: arbitration, door handshakes, pump phases and door-open hold
  always_comb begin
    nextState = state;
    nextSide = side;
    nextLeg = leg;
    nextSeen = doorSeen;
    nextOpened = anyOpened || outer_open || inner_open;
    nextLast = lastServed;
    nextPress = pressurized;
    faultNext = 1'b0;
    timerClear = 1'b0;
    case (state)
      IDLE: begin
        nextLeg = 1'b0;
        nextSeen = 1'b0;
        nextOpened = 1'b0;
        nextSide = arrive_req && depart_req ? (lastServed == ARRIVE ? DEPART : ARRIVE) : (arrive_req ? ARRIVE : DEPART);
        if (arrive_req || depart_req)
          nextState = nextSide == ARRIVE ? (pressurized ? WAIT_EVAC : DOOR_OUT) : (pressurized ? DOOR_IN : WAIT_PRESS);
      end
      DOOR_IN, DOOR_OUT: begin
        if (otherOpen) faultNext = 1'b1;
        else if (mineOpen) nextSeen = 1'b1;
        else if (doorSeen) begin
          nextSeen = 1'b0;
          nextLeg = 1'b1;
          nextState = leg ? IDLE : (state == DOOR_OUT ? WAIT_PRESS : WAIT_EVAC);
          if (leg) nextLast = side;
        end
      end
      WAIT_EVAC, WAIT_PRESS: begin
        if (!reqHeld && !leg && !anyOpened) nextState = IDLE;
        else if (doorsClosed && pumpGo) begin
          nextState = state == WAIT_EVAC ? EVAC : PRESS;
          timerClear = 1'b1;
        end
      end
      EVAC, PRESS: begin
        if (!doorsClosed) nextState = HOLD;
        else if (timerDone) begin
          nextPress = state == PRESS;
          nextState = state == EVAC ? DOOR_OUT : DOOR_IN;
        end
      end
      HOLD: begin
        if (doorsClosed) begin
          nextState = pressurized ? EVAC : PRESS;
          timerClear = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end
  // state and session bookkeeping, with outputs registered from the next-state decode
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      side <= ARRIVE;
      lastServed <= DEPART;
      leg <= 1'b0;
      doorSeen <= 1'b0;
      anyOpened <= 1'b0;
      pressurized <= 1'b1;
      grant_arrive <= 1'b0;
      grant_depart <= 1'b0;
      outer_ok <= 1'b0;
      inner_ok <= 1'b0;
      pumping <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nextState;
      side <= nextSide;
      lastServed <= nextLast;
      leg <= nextLeg;
      doorSeen <= nextSeen;
      anyOpened <= nextOpened;
      pressurized <= nextPress;
      grant_arrive <= nextState != IDLE && nextSide == ARRIVE;
      grant_depart <= nextState != IDLE && nextSide == DEPART;
      outer_ok <= nextState == DOOR_OUT;
      inner_ok <= nextState == DOOR_IN;
      pumping <= nextState == EVAC || nextState == PRESS;
      fault <= faultNext || nextState == HOLD;
    end
endmodule

// File: tb/tb_airlock_scheduler.sv
// tb_airlock_scheduler: randomized session-level bench for airlock_scheduler with a route/pressure/arbitration reference model
module tb_airlock_scheduler;
  localparam int EVAC_T = 5;
  localparam int PRESS_T = 7;
  localparam int W = 4;
  localparam int PH_EV = 0, PH_PR = 1, PH_OUT = 2, PH_IN = 3;
  logic clock = 1'b0, reset = 1'b0, tick = 1'b0, arrive_req = 1'b0, depart_req = 1'b0;
  logic outer_open = 1'b0, inner_open = 1'b0, evacuate = 1'b0, pressurize = 1'b0;
  logic grant_arrive, grant_depart, outer_ok, inner_ok, pumping, pressurized, fault;
  logic [W-1:0] seconds;
  int checks = 0, errors = 0;
  bit mPress = 1'b1;
  bit mLastDepart = 1'b1;
  always #5 clock = ~clock;
  airlock_scheduler #(.EVAC_TICKS(EVAC_T), .PRESS_TICKS(PRESS_T), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .tick(tick), .arrive_req(arrive_req), .depart_req(depart_req),
    .outer_open(outer_open), .inner_open(inner_open), .evacuate(evacuate), .pressurize(pressurize),
    .grant_arrive(grant_arrive), .grant_depart(grant_depart), .outer_ok(outer_ok), .inner_ok(inner_ok),
    .pumping(pumping), .pressurized(pressurized), .fault(fault), .seconds(seconds)
  );
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic test_reset();
    reset = 1'b0; tick = 0; arrive_req = 0; depart_req = 0; outer_open = 0; inner_open = 0; evacuate = 0; pressurize = 0;
    step(2);
    checks++;
    if (pressurized !== 1'b1 || pumping !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags: pressurized=%b pumping=%b fault=%b, want 1/0/0", pressurized, pumping, fault);
    end
    checks++;
    if ({grant_arrive, grant_depart, outer_ok, inner_ok} !== 4'b0 || seconds !== '0) begin
      errors++; $display("FAIL reset_outputs: grants/oks=%b seconds=%0d, want 0000/0", {grant_arrive, grant_depart, outer_ok, inner_ok}, seconds);
    end
    reset = 1'b1;
    step();
    mPress = 1'b1;
    mLastDepart = 1'b1;
  endtask
  task automatic request(input bit a, input bit d, output bit dep);
    dep = (a && d) ? !mLastDepart : d;
    arrive_req = a;
    depart_req = d;
    step();
    checks++;
    if (grant_arrive !== !dep || grant_depart !== dep) begin
      errors++; $display("FAIL grant: arrive=%b depart=%b, want %b/%b", grant_arrive, grant_depart, !dep, dep);
    end
  endtask
  task automatic start_pump(input bit evac);
    step($urandom_range(0, 3));
`ifdef AIRLOCK_AUTO_PUMP_EN
    tick = 1'b1;
    step();
    tick = 1'b0;
`else
    if (evac) evacuate = 1'b1; else pressurize = 1'b1;
    step();
    evacuate = 1'b0;
    pressurize = 1'b0;
`endif
    checks++;
    if (pumping !== 1'b1 || seconds !== '0) begin
      errors++; $display("FAIL pump_start: pumping=%b seconds=%0d, want 1/0", pumping, seconds);
    end
  endtask
  task automatic run_pump(input bit evac, input int holdAt);
    int n;
    n = evac ? EVAC_T : PRESS_T;
    start_pump(evac);
    if (holdAt >= 0) begin
      repeat (holdAt) begin
        tick = 1'b1; step(); tick = 1'b0;
      end
      outer_open = 1'b1;
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (fault !== 1'b1 || seconds !== W'(holdAt)) begin
        errors++; $display("FAIL hold_enter: fault=%b seconds=%0d, want 1/%0d", fault, seconds, holdAt);
      end
      tick = 1'b1; step(); tick = 1'b0;
      step(2);
      checks++;
      if (fault !== 1'b1 || seconds !== W'(holdAt)) begin
        errors++; $display("FAIL hold_frozen: fault=%b seconds=%0d, want 1/%0d", fault, seconds, holdAt);
      end
      outer_open = 1'b0;
      step();
      checks++;
      if (fault !== 1'b0 || pumping !== 1'b1 || seconds !== '0) begin
        errors++; $display("FAIL hold_exit: fault=%b pumping=%b seconds=%0d, want 0/1/0", fault, pumping, seconds);
      end
    end
    for (int i = 1; i <= n; i++) begin
      step($urandom_range(0, 2));
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i == n) mPress = !evac;
      checks++;
      if (pumping !== (i < n) || seconds !== (i < n ? W'(i) : W'(0)) || pressurized !== mPress) begin
        errors++; $display("FAIL pump_tick%0d: pumping=%b seconds=%0d pressurized=%b, want %b/%0d/%b", i, pumping, seconds, pressurized, i < n, i < n ? i : 0, mPress);
      end
    end
  endtask
  task automatic run_door(input bit outer, input bit last, input bit dep);
    checks++;
    if ((outer ? outer_ok : inner_ok) !== 1'b1 || (outer ? inner_ok : outer_ok) !== 1'b0) begin
      errors++; $display("FAIL door_permit: outer_ok=%b inner_ok=%b, want outer door=%b", outer_ok, inner_ok, outer);
    end
    step($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) begin
      if (outer) inner_open = 1'b1; else outer_open = 1'b1;
      step();
      checks++;
      if (fault !== 1'b1 || (outer ? outer_ok : inner_ok) !== 1'b1) begin
        errors++; $display("FAIL wrong_door: fault=%b permit=%b, want 1/1", fault, outer ? outer_ok : inner_ok);
      end
      inner_open = 1'b0;
      outer_open = 1'b0;
      step();
      checks++;
      if (fault !== 1'b0) begin
        errors++; $display("FAIL wrong_door_clear: fault=%b, want 0", fault);
      end
    end
    if (outer) outer_open = 1'b1; else inner_open = 1'b1;
    step($urandom_range(1, 3));
    checks++;
    if ((outer ? outer_ok : inner_ok) !== 1'b1) begin
      errors++; $display("FAIL door_open_hold: permit=%b, want 1", outer ? outer_ok : inner_ok);
    end
    if (last) begin
      if (dep) depart_req = 1'b0; else arrive_req = 1'b0;
    end
    outer_open = 1'b0;
    inner_open = 1'b0;
    step();
    checks++;
    if (outer_ok !== 1'b0 || inner_ok !== 1'b0 || (dep ? grant_depart : grant_arrive) !== !last || (dep ? grant_arrive : grant_depart) !== 1'b0) begin
      errors++; $display("FAIL door_close: oks=%b%b grant=%b, want 00 grant=%b", outer_ok, inner_ok, dep ? grant_depart : grant_arrive, !last);
    end
    if (last) mLastDepart = dep;
  endtask
  task automatic run_route(input bit dep, input int holdAt);
    int r[$];
    int h;
    h = holdAt;
    if (dep) begin
      if (!mPress) r.push_back(PH_PR);
      r.push_back(PH_IN); r.push_back(PH_EV); r.push_back(PH_OUT);
    end else begin
      if (mPress) r.push_back(PH_EV);
      r.push_back(PH_OUT); r.push_back(PH_PR); r.push_back(PH_IN);
    end
    for (int k = 0; k < r.size(); k++) begin
      if (r[k] == PH_EV) begin
        run_pump(1'b1, h);
        h = -1;
      end else if (r[k] == PH_PR) run_pump(1'b0, -1);
      else run_door(r[k] == PH_OUT, k == r.size() - 1, dep);
    end
  endtask
  task automatic test_arrive_session();
    bit dep;
    request(1'b1, 1'b0, dep);
    run_route(dep, -1);
    arrive_req = 1'b0;
  endtask
  task automatic test_back_to_back();
    bit dep;
    test_reset();
    request(1'b1, 1'b1, dep);
    run_route(dep, -1);
    step();
    checks++;
    if (grant_depart !== 1'b1 || grant_arrive !== 1'b0) begin
      errors++; $display("FAIL back_to_back: arrive=%b depart=%b, want 0/1", grant_arrive, grant_depart);
    end
    run_route(1'b1, -1);
    arrive_req = 1'b0;
    depart_req = 1'b0;
  endtask
  task automatic test_hold();
    bit dep;
    request(1'b0, 1'b1, dep);
    run_route(dep, 3);
    depart_req = 1'b0;
  endtask
  task automatic test_wrong_pulse();
    bit dep;
    request(1'b0, 1'b1, dep);
    evacuate = 1'b1;
    step();
    evacuate = 1'b0;
    checks++;
    if (pumping !== 1'b0 || grant_depart !== 1'b1) begin
      errors++; $display("FAIL wrong_pulse: pumping=%b grant_depart=%b, want 0/1", pumping, grant_depart);
    end
    evacuate = 1'b1;
    pressurize = 1'b1;
    step();
    evacuate = 1'b0;
    pressurize = 1'b0;
    checks++;
    if (pumping !== 1'b0) begin
      errors++; $display("FAIL both_pulses: pumping=%b, want 0", pumping);
    end
    run_route(dep, -1);
    depart_req = 1'b0;
  endtask
  task automatic test_random_sessions();
    bit a, d, dep;
    for (int s = 0; s < 6; s++) begin
      a = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!a && !d) a = 1'b1;
      request(a, d, dep);
      run_route(dep, $urandom_range(0, 1) == 1 ? int'($urandom_range(0, EVAC_T - 1)) : -1);
      arrive_req = 1'b0;
      depart_req = 1'b0;
      step($urandom_range(0, 2));
    end
  endtask
  task automatic test_abort();
    bit dep;
    if (!mPress) test_arrive_session();
    request(1'b1, 1'b0, dep);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outer_ok !== 1'b0 || inner_ok !== 1'b0 || grant_arrive !== 1'b1) begin
        errors++; $display("FAIL abort_wait: oks=%b%b grant=%b, want 00/1", outer_ok, inner_ok, grant_arrive);
      end
    end
    arrive_req = 1'b0;
    step();
    checks++;
    if (grant_arrive !== 1'b0 || outer_ok !== 1'b0 || inner_ok !== 1'b0 || pressurized !== mPress) begin
      errors++; $display("FAIL abort: grant=%b oks=%b%b pressurized=%b, want 0/00/%b", grant_arrive, outer_ok, inner_ok, pressurized, mPress);
    end
  endtask
  task automatic test_reset_in_press();
    bit dep;
    request(1'b1, 1'b0, dep);
    if (mPress) begin
      run_pump(1'b1, -1);
      run_door(1'b1, 1'b0, 1'b0);
    end else run_door(1'b1, 1'b0, 1'b0);
    start_pump(1'b0);
    repeat (2) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    checks++;
    if (pumping !== 1'b1 || seconds !== W'(2) || pressurized !== 1'b0) begin
      errors++; $display("FAIL press_running: pumping=%b seconds=%0d pressurized=%b, want 1/2/0", pumping, seconds, pressurized);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (pressurized !== 1'b1 || pumping !== 1'b0 || seconds !== '0 || {grant_arrive, grant_depart, outer_ok, inner_ok, fault} !== 5'b0) begin
      errors++; $display("FAIL async_reset: pressurized=%b pumping=%b seconds=%0d others=%b, want 1/0/0/00000", pressurized, pumping, seconds, {grant_arrive, grant_depart, outer_ok, inner_ok, fault});
    end
    arrive_req = 1'b0;
    step(2);
    reset = 1'b1;
    mPress = 1'b1;
    mLastDepart = 1'b1;
    step();
    checks++;
    if (grant_arrive !== 1'b0 || pressurized !== 1'b1) begin
      errors++; $display("FAIL after_reset: grant=%b pressurized=%b, want 0/1", grant_arrive, pressurized);
    end
  endtask
  initial begin
    test_reset();
    test_arrive_session();
    test_back_to_back();
    test_hold();
    test_wrong_pulse();
    test_random_sessions();
    test_abort();
    test_reset_in_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
